// File: rtl/register_skid.sv
`default_nettype none
// ============================================================================
//  Module   : register_skid
//  Purpose  : Two-entry valid/ready pipeline register (skid buffer). The load
//             enables are derived from the downstream handshake, and the
//             upstream ready depends only on flops, so no combinational path
//             runs from out_ready back to in_ready. A saturating counter
//             records cycles in which the output is stalled.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N          data width in bits
//    CW         stall counter width in bits
//  Ports
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset
//    in_data    upstream data
//    in_valid   upstream data valid
//    in_ready   block can accept (from flops only)
//    out_data   downstream data, driven straight from the main register
//    out_valid  downstream data valid (from flops only)
//    out_ready  downstream accepts
//    occupancy  number of entries held: 0, 1 or 2
//    stall_cnt  cycles with out_valid=1 and out_ready=0, saturating
//    stall_clr  synchronous clear of stall_cnt (wins over increment)
// ============================================================================
module register_skid #(
  parameter int N  = 1,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    occupancy,
  output logic [CW-1:0] stall_cnt,
  input  logic          stall_clr
);

  // State numbering matches the occupancy count, which keeps the occupancy
  // decode trivial, but the decode is still written out explicitly.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [CW-1:0] c_STALL_MAX = {CW{1'b1}};

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_main;
  logic [N-1:0]  r_skid;
  logic          r_rst_done;
  logic [CW-1:0] r_stall_cnt;

  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_ld_main_in;    // main <= in_data
  logic          w_ld_main_skid;  // main <= skid (drain of the skid entry)
  logic          w_ld_skid;       // skid <= in_data (absorb one extra word)

  // --------------------------------------------------------------------------
  // Handshake and output decode. Every term here comes from a flop, so
  // in_ready and out_valid carry no combinational path from any input.
  // --------------------------------------------------------------------------
  assign in_ready   = (r_state != S_FULL) && r_rst_done;
  assign out_valid  = (r_state != S_EMPTY);
  assign out_data   = r_main;
  assign stall_cnt  = r_stall_cnt;

  assign w_in_fire  = in_valid  && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (r_state)
      S_EMPTY: occupancy = 2'd0;
      S_BUSY:  occupancy = 2'd1;
      S_FULL:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and register load enables
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt  = S_BUSY;
          w_ld_main_in = 1'b1;
        end
      end
      S_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          // Pass-through: replace the departing word, no bubble.
          w_ld_main_in = 1'b1;
        end else if (w_in_fire) begin
          // Downstream stalled while a word was already accepted: park it.
          w_state_nxt = S_FULL;
          w_ld_skid   = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready is low here, so in_valid cannot cause a load.
        if (w_out_fire) begin
          w_state_nxt    = S_BUSY;
          w_ld_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Data registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
    end else if (w_ld_main_in) begin
      r_main <= in_data;
    end else if (w_ld_main_skid) begin
      r_main <= r_skid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid <= '0;
    end else if (w_ld_skid) begin
      r_skid <= in_data;
    end
  end

  // --------------------------------------------------------------------------
  // Reset-done flag: keeps in_ready low for the first cycle after reset
  // release so upstream never fires into a block still leaving reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Stall counter: clear wins over increment, increment saturates.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall_clr) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != c_STALL_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_skid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_skid
//  Purpose  : Self-checking bench for register_skid (N=8, CW=4). A queue-based
//             model of a two-deep FIFO is compared against the DUT on every
//             falling edge; directed steps add hand-computed literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_register_skid;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic          stall_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  register_skid #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: a FIFO of capacity two plus a saturating stall count.
  // --------------------------------------------------------------------------
  logic [N-1:0] m_q[$];
  int           m_stall = 0;
  bit           m_rst_done = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_stall    = 0;
        m_rst_done = 1'b0;
      end else begin
        bit acc, pop;
        acc = in_valid && m_rst_done && (m_q.size() < 2);
        pop = out_ready && (m_q.size() > 0);
        if (stall_clr) m_stall = 0;
        else if (m_q.size() > 0 && !out_ready && m_stall < 15) m_stall++;
        if (pop) void'(m_q.pop_front());
        if (acc) m_q.push_back(in_data);
        m_rst_done = 1'b1;
      end
    end
  end

  // Compare process: every falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("m_in_ready", {31'b0, in_ready}, {31'b0, m_rst_done && (m_q.size() < 2)});
    chk("m_out_valid", {31'b0, out_valid}, {31'b0, m_q.size() > 0});
    chk("m_occupancy", {30'b0, occupancy}, m_q.size());
    chk("m_stall_cnt", {28'b0, stall_cnt}, m_stall);
    if (m_q.size() > 0) chk("m_out_data", {24'b0, out_data}, {24'b0, m_q[0]});
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (3) tick();
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_occupancy", {30'b0, occupancy}, 0);
    chk("rst_stall", {28'b0, stall_cnt}, 0);
    chk("rst_out_data", {24'b0, out_data}, 0);
    rst_n = 1'b1;
    #1 chk("rel_in_ready0", {31'b0, in_ready}, 0);
    tick();
    chk("rel_in_ready1", {31'b0, in_ready}, 1);

    // ---------------- streaming 0..15 ----------------
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
      chk("stream_data", {24'b0, out_data}, i);
      chk("stream_occ", {30'b0, occupancy}, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_empty", {31'b0, out_valid}, 0);
    chk("stream_stall", {28'b0, stall_cnt}, 0);

    // ---------------- back-pressure A,B,C ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA1;
    tick();
    in_data = 8'hB2;
    tick();
    in_data = 8'hC3;
    tick();
    tick();
    chk("bp_occ", {30'b0, occupancy}, 2);
    chk("bp_in_ready", {31'b0, in_ready}, 0);
    chk("bp_head", {24'b0, out_data}, 32'hA1);
    chk("bp_stall", {28'b0, stall_cnt}, 3);
    out_ready = 1'b1;
    tick();
    chk("bp_second", {24'b0, out_data}, 32'hB2);
    chk("bp_ready_back", {31'b0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_third", {24'b0, out_data}, 32'hC3);
    chk("bp_occ_c", {30'b0, occupancy}, 1);
    tick();
    chk("bp_done", {31'b0, out_valid}, 0);
    chk("bp_stall_hold", {28'b0, stall_cnt}, 3);

    // ---------------- drain from FULL ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("drain_full", {30'b0, occupancy}, 2);
    tick();
    chk("drain_v1", {31'b0, out_valid}, 1);
    chk("drain_d1", {24'b0, out_data}, 32'h22);
    tick();
    chk("drain_v0", {31'b0, out_valid}, 0);
    chk("drain_occ0", {30'b0, occupancy}, 0);

    // ---------------- stall counter saturation and clear ----------------
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h33;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_15", {28'b0, stall_cnt}, 15);
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    chk("clr_0", {28'b0, stall_cnt}, 0);
    tick();
    chk("resume_1", {28'b0, stall_cnt}, 1);

    // ---------------- reset while FULL ----------------
    in_valid = 1'b1;
    in_data  = 8'h44;
    tick();
    chk("pre_rst_occ", {30'b0, occupancy}, 2);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_occ", {30'b0, occupancy}, 0);
    chk("mid_rst_data", {24'b0, out_data}, 0);
    chk("mid_rst_stall", {28'b0, stall_cnt}, 0);
    chk("mid_rst_ready", {31'b0, in_ready}, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    #1 chk("post_rst_ready0", {31'b0, in_ready}, 0);
    tick();
    chk("post_rst_ready1", {31'b0, in_ready}, 1);
    chk("post_rst_notyet", {31'b0, out_valid}, 0);
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", {31'b0, out_valid}, 1);
    chk("post_rst_data", {24'b0, out_data}, 32'h5A);
    tick();

    // ---------------- random traffic ----------------
    for (int c = 0; c < 10000; c++) begin
      // Hold a word that is being offered but not yet taken.
      if (!(in_valid && !in_ready)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      stall_clr = ($urandom_range(0, 63) == 0);
      tick();
    end
    in_valid  = 1'b0;
    stall_clr = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("final_empty", {30'b0, occupancy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
